// File: rtl/count_share_arb_if.sv
// Bundles the request and grant signals shared between the requesting agents and the arbiter.
interface count_share_arb_if #(
  parameter int NREQ = 4,
  parameter int CW   = 3,
  parameter int TW   = 3
);
  logic [NREQ-1:0]    req;
  logic               hold;
  logic               clr_tally;
  logic [NREQ-1:0]    gnt;
  logic [2:0]         gnt_id;
  logic [CW-1:0]      count;
  logic               wrap;
  logic               busy;
  logic [NREQ*TW-1:0] tally;

  // Requesting side: drives requests and control, observes grants.
  modport master (
    output req, hold, clr_tally,
    input  gnt, gnt_id, count, wrap, busy, tally
  );

  // Arbiter side.
  modport slave (
    input  req, hold, clr_tally,
    output gnt, gnt_id, count, wrap, busy, tally
  );
endinterface

// File: rtl/count_share_arb.sv
// Round-robin arbiter that shares one modulo-MODULUS step counter among NREQ requesters.
// Every grant advances the shared count by one and bumps the grantee's saturating tally.
//
// state | meaning
// IDLE  | no grant this cycle, gnt = 0
// GNT   | exactly one gnt bit high; that requester is masked for the next decision
module count_share_arb #(
  parameter int NREQ    = 4,
  parameter int MODULUS = 5,
  parameter int CW      = 3,
  parameter int TW      = 3
) (
  input logic              clk,
  input logic              reset,
  count_share_arb_if.slave bus
);

  typedef enum logic {IDLE, GNT} state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [2:0]         gnt_id_q, gnt_id_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               wrap_q, wrap_d;
  logic [NREQ*TW-1:0] tally_q, tally_d;

  logic [NREQ-1:0]    elig;
  logic [2*NREQ-1:0]  elig_rot;
  logic               found;
  logic [2:0]         pick;

  // gnt_q is zero in IDLE, so masking with it only affects the current grantee in GNT.
  assign elig     = bus.req & ~gnt_q;
  assign elig_rot = {elig, elig} >> rr_ptr_q;

  // Round-robin search from rr_ptr upward, then next-state for grant, count and tally.
  always_comb begin
    state_d  = IDLE;
    gnt_d    = '0;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    wrap_d   = 1'b0;
    tally_d  = tally_q;
    found    = 1'b0;
    pick     = '0;

    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig_rot[k]) begin
        found = 1'b1;
        pick  = 3'((int'(rr_ptr_q) + k) % NREQ);
      end
    end

    if (!bus.hold && found) begin
      state_d  = GNT;
      gnt_d    = NREQ'(1) << pick;
      gnt_id_d = pick;
      rr_ptr_d = (pick == 3'(NREQ - 1)) ? 3'd0 : pick + 3'd1;
      if (count_q == CW'(MODULUS - 1)) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (pick == 3'(i) && tally_q[i*TW +: TW] != {TW{1'b1}}) begin
          tally_d[i*TW +: TW] = tally_q[i*TW +: TW] + 1'b1;
        end
      end
    end

    // Clear takes precedence over a same-edge grant; the count still advances.
    if (bus.clr_tally) begin
      tally_d = '0;
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      wrap_q   <= 1'b0;
      tally_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      tally_q  <= tally_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.count  = count_q;
  assign bus.wrap   = wrap_q;
  assign bus.busy   = (state_q == GNT);
  assign bus.tally  = tally_q;

endmodule

// File: tb/tb_count_share_arb.sv
// Directed bench for count_share_arb with hand-computed expected grant, count and tally sequences.
module tb_count_share_arb;
  localparam int NREQ    = 4;
  localparam int MODULUS = 5;
  localparam int CW      = 3;
  localparam int TW      = 3;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_share_arb_if #(.NREQ(NREQ), .CW(CW), .TW(TW)) bus ();

  count_share_arb #(.NREQ(NREQ), .MODULUS(MODULUS), .CW(CW), .TW(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] tally_of(input int i);
    return 32'(bus.tally[i*TW +: TW]);
  endfunction

  task automatic do_reset();
    reset         = 1'b1;
    bus.req       = '0;
    bus.hold      = 1'b0;
    bus.clr_tally = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Single-requester pattern: grant on every other edge.
  logic [3:0] s1_gnt  [12] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
  logic [2:0] s1_cnt  [12] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0, 3'd0, 3'd1, 3'd1};
  logic       s1_wrap [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

  // All requesters contending.
  logic [3:0] s2_gnt  [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [2:0] s2_id   [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
  logic [2:0] s2_cnt  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic       s2_wrap [5] = '{0, 0, 0, 0, 1};

  initial begin
    reset         = 1'b1;
    bus.req       = '0;
    bus.hold      = 1'b0;
    bus.clr_tally = 1'b0;
    do_reset();

    chk("rst_gnt",    32'(bus.gnt),    32'h0);
    chk("rst_count",  32'(bus.count),  32'h0);
    chk("rst_wrap",   32'(bus.wrap),   32'h0);
    chk("rst_busy",   32'(bus.busy),   32'h0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 32'h0);
    chk("rst_tally",  32'(bus.tally),  32'h0);

    bus.req = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("s1_gnt[%0d]", c),  32'(bus.gnt),   32'(s1_gnt[c]));
      chk($sformatf("s1_cnt[%0d]", c),  32'(bus.count), 32'(s1_cnt[c]));
      chk($sformatf("s1_wrap[%0d]", c), 32'(bus.wrap),  32'(s1_wrap[c]));
      chk($sformatf("s1_busy[%0d]", c), 32'(bus.busy),  32'(s1_gnt[c] != 4'h0));
    end
    chk("s1_tally0", tally_of(0), 32'd6);

    do_reset();
    bus.req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("s2_gnt[%0d]", c),  32'(bus.gnt),    32'(s2_gnt[c]));
      chk($sformatf("s2_id[%0d]", c),   32'(bus.gnt_id), 32'(s2_id[c]));
      chk($sformatf("s2_cnt[%0d]", c),  32'(bus.count),  32'(s2_cnt[c]));
      chk($sformatf("s2_wrap[%0d]", c), 32'(bus.wrap),   32'(s2_wrap[c]));
      chk($sformatf("s2_busy[%0d]", c), 32'(bus.busy),   32'h1);
    end

    do_reset();
    bus.req = 4'b1111;
    tick(); chk("s3_g0", 32'(bus.gnt), 32'h1);
    tick(); chk("s3_g1", 32'(bus.gnt), 32'h2);
    tick(); chk("s3_g2", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0110;
    tick(); chk("s3_g3", 32'(bus.gnt), 32'h2);
    tick(); chk("s3_g4", 32'(bus.gnt), 32'h4);
    chk("s3_id", 32'(bus.gnt_id), 32'd2);
    chk("s3_cnt", 32'(bus.count), 32'd0);

    bus.req  = 4'b1111;
    bus.hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("s4_hold_gnt[%0d]", c),  32'(bus.gnt),   32'h0);
      chk($sformatf("s4_hold_cnt[%0d]", c),  32'(bus.count), 32'h0);
      chk($sformatf("s4_hold_busy[%0d]", c), 32'(bus.busy),  32'h0);
      chk($sformatf("s4_hold_wrap[%0d]", c), 32'(bus.wrap),  32'h0);
    end
    bus.hold = 1'b0;
    tick();
    chk("s4_resume_gnt", 32'(bus.gnt),    32'h8);
    chk("s4_resume_id",  32'(bus.gnt_id), 32'd3);
    chk("s4_resume_cnt", 32'(bus.count),  32'd1);
    tick();
    chk("s4_next_gnt", 32'(bus.gnt),   32'h1);
    chk("s4_next_cnt", 32'(bus.count), 32'd2);

    do_reset();
    bus.req = 4'b0001;
    for (int e = 1; e <= 18; e++) begin
      tick();
      if (e == 13) chk("s5_tally_7th", tally_of(0), 32'd7);
    end
    chk("s5_tally_sat", tally_of(0), 32'd7);
    chk("s5_cnt9", 32'(bus.count), 32'd4);
    bus.clr_tally = 1'b1;
    tick();
    bus.clr_tally = 1'b0;
    chk("s5_clr_gnt",   32'(bus.gnt),   32'h1);
    chk("s5_clr_tally", 32'(bus.tally), 32'h0);
    chk("s5_clr_cnt",   32'(bus.count), 32'd0);
    chk("s5_clr_wrap",  32'(bus.wrap),  32'h1);
    tick();
    tick();
    chk("s5_after_tally", tally_of(0), 32'd1);
    chk("s5_after_cnt",   32'(bus.count), 32'd1);

    do_reset();
    bus.req = 4'b1111;
    tick();
    tick();
    tick();
    chk("s6_pre_cnt",  32'(bus.count), 32'd3);
    chk("s6_pre_busy", 32'(bus.busy),  32'h1);
    chk("s6_pre_gnt",  32'(bus.gnt),   32'h4);
    reset = 1'b1;
    #1;
    chk("s6_async_gnt",   32'(bus.gnt),    32'h0);
    chk("s6_async_wrap",  32'(bus.wrap),   32'h0);
    chk("s6_async_busy",  32'(bus.busy),   32'h0);
    chk("s6_async_cnt",   32'(bus.count),  32'h0);
    chk("s6_async_id",    32'(bus.gnt_id), 32'h0);
    chk("s6_async_tally", 32'(bus.tally),  32'h0);
    bus.req = 4'b0110;
    #2;
    reset = 1'b0;
    #1;
    chk("s6_post_rel_gnt", 32'(bus.gnt), 32'h0);
    tick();
    chk("s6_first_gnt", 32'(bus.gnt),    32'h2);
    chk("s6_first_id",  32'(bus.gnt_id), 32'd1);
    chk("s6_first_cnt", 32'(bus.count),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
